// File: rtl/pong_input_ctrl.sv
// pong_input_ctrl: input conditioner for the Pong state machine.
// Synchronizes and debounces the five raw board buttons, produces the
// per-player 2-bit direction codes and a one-cycle start pulse.
// Optional feature macro: PONG_CPU_PLAYER_EN. When defined, the right-hand
// player is driven by a tracking CPU opponent instead of the right buttons.
module pong_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CPU_DEADBAND    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_left_up,
  input  logic       btn_left_down,
  input  logic       btn_right_up,
  input  logic       btn_right_down,
  input  logic [9:0] ball_pos_y,
  input  logic [9:0] ball_size,
  input  logic [9:0] player_right_pos,
  input  logic [9:0] paddle_height,
  output logic       start_game,
  output logic [1:0] player_left_input,
  output logic [1:0] player_right_input
);

  localparam int NBTN  = 5;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count value before a flip: the incremented value would hit DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button order: 0 start, 1 left up, 2 left down, 3 right up, 4 right down.
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] s1;
  logic [NBTN-1:0] s2;
  logic [NBTN-1:0] db;
  logic            db_start_q;

  assign raw = {btn_right_down, btn_right_up, btn_left_down, btn_left_up, btn_start};

  // Up wins only when down is released, and vice versa; both pressed is idle.
  function automatic logic [1:0] dir_code(input logic up, input logic down);
    return {up & ~down, down & ~up};
  endfunction

  // Two-flop synchronizer for every raw button (asynchronous to clk).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             db_bit;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        db_bit <= 1'b0;
      end else if (s2[i] != db_bit) begin
        if (cnt == CNT_LAST) begin
          db_bit <= s2[i];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign db[i] = db_bit;
  end

  // One-cycle delayed copy of the debounced start for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_start_q <= 1'b0;
    end else begin
      db_start_q <= db[0];
    end
  end

  assign start_game        = db[0] & ~db_start_q;
  assign player_left_input = dir_code(db[1], db[2]);

`ifdef PONG_CPU_PLAYER_EN
  // Midpoints held at 11 bits so ball/paddle sums near the screen edge never wrap.
  localparam logic [10:0] DEADBAND = 11'(CPU_DEADBAND);

  logic [10:0] ball_mid;
  logic [10:0] paddle_mid;
  logic [1:0]  cpu_dir;
  logic        unused_right;

  assign ball_mid     = {1'b0, ball_pos_y} + {2'b00, ball_size[9:1]};
  assign paddle_mid   = {1'b0, player_right_pos} + {2'b00, paddle_height[9:1]};
  assign unused_right = ^db[4:3];

  // CPU opponent: steer the paddle centre toward the ball centre outside the dead zone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dir <= 2'b00;
    end else if (ball_mid + DEADBAND < paddle_mid) begin
      cpu_dir <= 2'b10;
    end else if (ball_mid > paddle_mid + DEADBAND) begin
      cpu_dir <= 2'b01;
    end else begin
      cpu_dir <= 2'b00;
    end
  end

  assign player_right_input = cpu_dir;
`else
  logic unused_pos;

  assign unused_pos         = ^{ball_pos_y, ball_size, player_right_pos, paddle_height};
  assign player_right_input = dir_code(db[3], db[4]);
`endif

endmodule

// File: tb/tb_pong_input_ctrl.sv
// tb_pong_input_ctrl: directed and randomized checks of pong_input_ctrl
// against a window-based debounce reference model (DEBOUNCE_CYCLES=4).
module tb_pong_input_ctrl;
  localparam int D    = 4;
  localparam int DB   = 4;
  localparam int MAXE = 4096;

  localparam logic [4:0] START = 5'b00001;
  localparam logic [4:0] LU    = 5'b00010;
  localparam logic [4:0] LD    = 5'b00100;
  localparam logic [4:0] RD    = 5'b10000;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_left_up, btn_left_down, btn_right_up, btn_right_down;
  logic [9:0] ball_pos_y, ball_size, player_right_pos, paddle_height;
  logic       start_game;
  logic [1:0] player_left_input, player_right_input;

  pong_input_ctrl #(.DEBOUNCE_CYCLES(D), .CPU_DEADBAND(DB)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_left_up(btn_left_up), .btn_left_down(btn_left_down),
    .btn_right_up(btn_right_up), .btn_right_down(btn_right_down),
    .ball_pos_y(ball_pos_y), .ball_size(ball_size),
    .player_right_pos(player_right_pos), .paddle_height(paddle_height),
    .start_game(start_game), .player_left_input(player_left_input),
    .player_right_input(player_right_input)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: raw level seen at each edge since reset, edge index,
  // debounced levels and the edge at which each one last changed.
  bit         raw_hist [5][MAXE];
  int         e;
  int         last_flip [5];
  bit         mdb [5];
  bit         exp_start;
  logic [1:0] exp_l, exp_r;
  bit         rand_pos;

  // Synchronizer output in effect at edge k: the raw level two edges earlier.
  function automatic bit s2_at(int b, int k);
    return (k >= 3) ? raw_hist[b][k-2] : 1'b0;
  endfunction

  function automatic logic [1:0] enc(bit up, bit down);
    if (up && !down) return 2'b10;
    if (down && !up) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] cpu_model();
    int bm, pm;
    bm = int'(ball_pos_y) + int'(ball_size) / 2;
    pm = int'(player_right_pos) + int'(paddle_height) / 2;
    if (bm + DB < pm) return 2'b10;
    if (bm > pm + DB) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int b = 0; b < 5; b++) begin
      mdb[b] = 1'b0;
      last_flip[b] = 0;
    end
    exp_start = 1'b0;
    exp_l = 2'b00;
    exp_r = 2'b00;
  endtask

  // A level flips once the last D synchronized samples all disagree with it,
  // and all of those samples came after its previous flip.
  task automatic model_edge();
    bit prev_start, all_diff;
    e++;
    prev_start = mdb[0];
    for (int b = 0; b < 5; b++) begin
      if (e - last_flip[b] >= D) begin
        all_diff = 1'b1;
        for (int j = e - D + 1; j <= e; j++)
          if (s2_at(b, j) == mdb[b]) all_diff = 1'b0;
        if (all_diff) begin
          mdb[b] = !mdb[b];
          last_flip[b] = e;
        end
      end
    end
    exp_start = mdb[0] && !prev_start;
    exp_l = enc(mdb[1], mdb[2]);
`ifdef PONG_CPU_PLAYER_EN
    exp_r = cpu_model();
`else
    exp_r = enc(mdb[3], mdb[4]);
`endif
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, got, want);
    end
  endtask

  task automatic check_model();
    chk("start_game", {1'b0, start_game}, {1'b0, exp_start});
    chk("left_dir", player_left_input, exp_l);
    chk("right_dir", player_right_input, exp_r);
  endtask

  // Drive one cycle of buttons (bit0 start .. bit4 right down), clock, check.
  task automatic step(input logic [4:0] b);
    {btn_right_down, btn_right_up, btn_left_down, btn_left_up, btn_start} = b;
    for (int i = 0; i < 5; i++) raw_hist[i][e+1] = b[i];
    if (rand_pos) begin
      ball_pos_y       = 10'($urandom_range(0, 1023));
      ball_size        = 10'($urandom_range(0, 63));
      player_right_pos = 10'($urandom_range(0, 1023));
      paddle_height    = 10'($urandom_range(0, 127));
    end
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int pulses, pulse_at;
    logic [4:0] cur;

    reset = 1'b1;
    {btn_right_down, btn_right_up, btn_left_down, btn_left_up, btn_start} = '0;
    ball_pos_y = '0; ball_size = '0; player_right_pos = '0; paddle_height = '0;
    rand_pos = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_start", {1'b0, start_game}, 2'b00);
    chk("reset_left", player_left_input, 2'b00);
    chk("reset_right", player_right_input, 2'b00);
    reset = 1'b0;

    // Reset mid-debounce: left up debounced, then released, reset while counting down.
    repeat (8) step(LU);
    chk("left_up_held", player_left_input, 2'b10);
    repeat (3) step(5'b00000);
    reset = 1'b1;
    #1;
    chk("async_reset_start", {1'b0, start_game}, 2'b00);
    chk("async_reset_left", player_left_input, 2'b00);
    chk("async_reset_right", player_right_input, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 6; i++) begin
      step(LU);
      if (i == 5) chk("fresh_count_edge5", player_left_input, 2'b00);
      if (i == 6) chk("fresh_count_edge6", player_left_input, 2'b10);
    end
    repeat (6) step(5'b00000);

    // Glitch rejection on start: 3 high, 1 low, 3 high.
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step((i < 3 || (i >= 4 && i < 7)) ? START : 5'b00000);
      if (start_game) pulses++;
    end
    chk("glitch_no_pulse", 2'(pulses), 2'd0);

    // Long hold: exactly one pulse, at edge 6, then nothing on release.
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(START);
      if (start_game) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("hold_one_pulse", 2'(pulses), 2'd1);
    chk("hold_pulse_edge", 2'(pulse_at - 4), 2'd2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(5'b00000);
      if (start_game) pulses++;
    end
    chk("release_no_pulse", 2'(pulses), 2'd0);

    // Both left buttons: idle; releasing down yields up after 6 edges.
    repeat (8) step(LU | LD);
    chk("both_pressed", player_left_input, 2'b00);
    for (int i = 1; i <= 6; i++) begin
      step(LU);
      if (i == 5) chk("release_down_edge5", player_left_input, 2'b00);
      if (i == 6) chk("release_down_edge6", player_left_input, 2'b10);
    end
    repeat (6) step(5'b00000);

`ifndef PONG_CPU_PLAYER_EN
    // Right-player buttons with positions toggling every cycle.
    for (int i = 1; i <= 6; i++) begin
      step(RD);
      if (i == 5) chk("right_down_edge5", player_right_input, 2'b00);
      if (i == 6) chk("right_down_edge6", player_right_input, 2'b01);
    end
    repeat (6) step(5'b00000);
`else
    // CPU opponent: fixed geometry, right buttons rattling underneath.
    rand_pos = 1'b0;
    ball_pos_y = 10'd100; ball_size = 10'd10; paddle_height = 10'd40;
    player_right_pos = 10'd200;
    step({2'($urandom), 3'b000});
    chk("cpu_up", player_right_input, 2'b10);
    player_right_pos = 10'd50;
    step({2'($urandom), 3'b000});
    chk("cpu_down", player_right_input, 2'b01);
    player_right_pos = 10'd83;
    step({2'($urandom), 3'b000});
    chk("cpu_deadband", player_right_input, 2'b00);
    ball_pos_y = 10'd1020; player_right_pos = 10'd0;
    step({2'($urandom), 3'b000});
    chk("cpu_no_wrap", player_right_input, 2'b01);
    rand_pos = 1'b1;
`endif

    // Randomized button activity with sticky levels so some presses survive debounce.
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
      step(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
